// File: rtl/device_register_sink_if.sv
// Register-transfer link between the device-data collector and the register sink,
// together with the sink's read port and status outputs.
interface device_register_sink_if;
   logic        TR_IN;
   logic [15:0] ADDR_IN;
   logic [31:0] DATA_IN;
   logic        TR_IN_BUSY;
   logic [15:0] RD_ADDR;
   logic [31:0] RD_DATA;
   logic        UPD;
   logic [15:0] UPD_ADDR;
   logic [7:0]  ERR_CNT;
   logic [7:0]  OVF_CNT;

   modport master (
      output TR_IN, ADDR_IN, DATA_IN, RD_ADDR,
      input  TR_IN_BUSY, RD_DATA, UPD, UPD_ADDR, ERR_CNT, OVF_CNT
   );

   modport slave (
      input  TR_IN, ADDR_IN, DATA_IN, RD_ADDR,
      output TR_IN_BUSY, RD_DATA, UPD, UPD_ADDR, ERR_CNT, OVF_CNT
   );
endinterface

// File: rtl/device_register_sink.sv
// Register sink: buffers write strobes in a small FIFO and drains them, one every
// three cycles, into a status register bank with a registered read port.
module device_register_sink #(
   parameter int BASE_ADDR  = 300,
   parameter int NUM_REGS   = 21,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   device_register_sink_if.slave  bus
);

   localparam int          PTR_W   = $clog2(FIFO_DEPTH);
   localparam int          CNT_W   = PTR_W + 1;
   localparam int          IDX_W   = $clog2(NUM_REGS);
   localparam logic [15:0] ADDR_LO = 16'(BASE_ADDR);
   localparam logic [15:0] ADDR_HI = 16'(BASE_ADDR + NUM_REGS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        hold_addr_q, hold_addr_d;
   logic [31:0]        hold_data_q, hold_data_d;
   logic               upd_q, upd_d;
   logic [15:0]        upd_addr_q, upd_addr_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic [7:0]         ovf_cnt_q, ovf_cnt_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic [31:0]        bank_q [NUM_REGS];
   logic [31:0]        bank_d [NUM_REGS];
   logic [47:0]        fifo_mem_q [FIFO_DEPTH];

   logic               busy;
   logic               push;
   logic               pop;
   logic               bank_we;
   logic               hold_in_range;
   logic               rd_in_range;
   logic [IDX_W-1:0]   bank_idx;
   logic [IDX_W-1:0]   rd_idx;

   // Busy comes from the registered count only, so a pop in the same cycle cannot rescue a strobe.
   assign busy = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign push = bus.TR_IN && !busy;

   assign hold_in_range = (hold_addr_q >= ADDR_LO) && (hold_addr_q < ADDR_HI);
   assign bank_idx      = IDX_W'(hold_addr_q - ADDR_LO);
   assign rd_in_range   = (bus.RD_ADDR >= ADDR_LO) && (bus.RD_ADDR < ADDR_HI);
   assign rd_idx        = IDX_W'(bus.RD_ADDR - ADDR_LO);

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {bus.ADDR_IN, bus.DATA_IN};
      end
   end

   always_comb begin
      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d     = cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (bus.TR_IN && busy && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      bank_we     = 1'b0;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      upd_d       = 1'b0;
      upd_addr_d  = upd_addr_q;
      err_cnt_d   = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q != '0) state_d = ST_POP;
         end
         ST_POP: begin
            pop         = 1'b1;
            hold_addr_d = fifo_mem_q[rd_ptr_q][47:32];
            hold_data_d = fifo_mem_q[rd_ptr_q][31:0];
            state_d     = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (hold_in_range) begin
               bank_we    = 1'b1;
               upd_d      = 1'b1;
               upd_addr_d = hold_addr_q;
            end else if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The read samples bank_q before this edge's commit lands, so a colliding read returns the old word.
   always_comb begin
      bank_d = bank_q;
      if (bank_we) bank_d[bank_idx] = hold_data_q;
      rd_data_d = rd_in_range ? bank_q[rd_idx] : 32'h0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         upd_q       <= 1'b0;
         upd_addr_q  <= '0;
         err_cnt_q   <= '0;
         ovf_cnt_q   <= '0;
         rd_data_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         upd_q       <= upd_d;
         upd_addr_q  <= upd_addr_d;
         err_cnt_q   <= err_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
         rd_data_q   <= rd_data_d;
         bank_q      <= bank_d;
      end
   end

   assign bus.TR_IN_BUSY = busy;
   assign bus.RD_DATA    = rd_data_q;
   assign bus.UPD        = upd_q;
   assign bus.UPD_ADDR   = upd_addr_q;
   assign bus.ERR_CNT    = err_cnt_q;
   assign bus.OVF_CNT    = ovf_cnt_q;

endmodule

// File: tb/tb_device_register_sink.sv
// Randomised and directed bench for device_register_sink, checked every cycle against
// a queue-based transaction model of the FIFO, drain latency and register bank.
module tb_device_register_sink;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   device_register_sink_if bus_if ();

   device_register_sink #(
      .BASE_ADDR (300),
      .NUM_REGS  (21),
      .FIFO_DEPTH(4)
   ) dut (
      .CLK    (clk),
      .RESET_N(rst_n),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, each entry costs one wait, one pop and one commit edge.
   logic [47:0] m_q [$];
   logic [31:0] m_bank [21];
   int          m_phase;
   logic [15:0] m_hold_addr;
   logic [31:0] m_hold_data;
   logic        m_upd;
   logic [15:0] m_upd_addr;
   logic [31:0] m_rd;
   int          m_err;
   int          m_ovf;

   function automatic bit in_range(logic [15:0] a);
      return (a >= 16'd300) && (a < 16'd321);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < 21; i++) m_bank[i] = 32'h0;
      m_phase     = 0;
      m_hold_addr = '0;
      m_hold_data = '0;
      m_upd       = 1'b0;
      m_upd_addr  = '0;
      m_rd        = '0;
      m_err       = 0;
      m_ovf       = 0;
   endtask

   task automatic model_step();
      bit          full;
      int          sz;
      logic [47:0] head;
      full = (m_q.size() == 4);
      sz   = m_q.size();
      m_rd = in_range(bus_if.RD_ADDR) ? m_bank[bus_if.RD_ADDR - 16'd300] : 32'h0;
      m_upd = 1'b0;
      case (m_phase)
         0: if (sz != 0) m_phase = 1;
         1: begin
            head        = m_q.pop_front();
            m_hold_addr = head[47:32];
            m_hold_data = head[31:0];
            m_phase     = 2;
         end
         default: begin
            if (in_range(m_hold_addr)) begin
               m_bank[m_hold_addr - 16'd300] = m_hold_data;
               m_upd      = 1'b1;
               m_upd_addr = m_hold_addr;
            end else if (m_err < 255) begin
               m_err++;
            end
            m_phase = 0;
         end
      endcase
      if (bus_if.TR_IN) begin
         if (full) begin
            if (m_ovf < 255) m_ovf++;
            $display("txn addr=%0d data=0x%08h refused", bus_if.ADDR_IN, bus_if.DATA_IN);
         end else begin
            m_q.push_back({bus_if.ADDR_IN, bus_if.DATA_IN});
            $display("txn addr=%0d data=0x%08h accepted", bus_if.ADDR_IN, bus_if.DATA_IN);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("busy",     32'(bus_if.TR_IN_BUSY), 32'(m_q.size() == 4));
      chk("rd_data",  bus_if.RD_DATA,         m_rd);
      chk("upd",      32'(bus_if.UPD),        32'(m_upd));
      chk("upd_addr", 32'(bus_if.UPD_ADDR),   32'(m_upd_addr));
      chk("err_cnt",  32'(bus_if.ERR_CNT),    32'(m_err));
      chk("ovf_cnt",  32'(bus_if.OVF_CNT),    32'(m_ovf));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic strobe(logic [15:0] a, logic [31:0] d);
      bus_if.TR_IN   = 1'b1;
      bus_if.ADDR_IN = a;
      bus_if.DATA_IN = d;
      tick();
      bus_if.TR_IN   = 1'b0;
   endtask

   task automatic read_chk(string tag, logic [15:0] a, logic [31:0] exp);
      bus_if.RD_ADDR = a;
      tick();
      chk(tag, bus_if.RD_DATA, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_busy",     32'(bus_if.TR_IN_BUSY), 32'h0);
      chk("rst_rd_data",  bus_if.RD_DATA,         32'h0);
      chk("rst_upd",      32'(bus_if.UPD),        32'h0);
      chk("rst_upd_addr", 32'(bus_if.UPD_ADDR),   32'h0);
      chk("rst_err_cnt",  32'(bus_if.ERR_CNT),    32'h0);
      chk("rst_ovf_cnt",  32'(bus_if.OVF_CNT),    32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          lat;
      logic [31:0] old_word;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus_if.TR_IN   = 1'b0;
      bus_if.ADDR_IN = '0;
      bus_if.DATA_IN = '0;
      bus_if.RD_ADDR = '0;
      model_reset();
      do_reset();

      // Single write and its latency to the UPD pulse.
      strobe(16'd300, 32'h0000_0001);
      lat = 0;
      while (bus_if.UPD !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk("single_latency", 32'(lat), 32'd3);
      chk("single_upd_addr", 32'(bus_if.UPD_ADDR), 32'd300);
      read_chk("single_read", 16'd300, 32'h0000_0001);

      // Burst of six back-to-back strobes.
      for (int i = 0; i < 6; i++) begin
         bus_if.TR_IN   = 1'b1;
         bus_if.ADDR_IN = 16'(301 + i);
         bus_if.DATA_IN = 32'(8'hA0 + i);
         tick();
      end
      bus_if.TR_IN = 1'b0;
      idle(20);
      for (int i = 0; i < 6; i++) begin
         read_chk("burst_read", 16'(301 + i), m_bank[1 + i]);
      end

      // Range edges.
      strobe(16'd299, 32'h1111_1111);
      idle(3);
      strobe(16'd320, 32'h2222_2222);
      idle(3);
      strobe(16'd321, 32'h3333_3333);
      idle(3);
      chk("range_err", 32'(bus_if.ERR_CNT), 32'd2);
      read_chk("range_320", 16'd320, 32'h2222_2222);
      read_chk("range_299", 16'd299, 32'h0);
      read_chk("range_321", 16'd321, 32'h0);

      // Read/write collision on 310.
      bus_if.RD_ADDR = 16'd310;
      old_word = m_bank[10];
      strobe(16'd310, 32'hDEAD_BEEF);
      lat = 0;
      while (bus_if.UPD !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk("coll_old", bus_if.RD_DATA, old_word);
      tick();
      chk("coll_new", bus_if.RD_DATA, 32'hDEAD_BEEF);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bus_if.TR_IN   = ($urandom_range(0, 2) == 0);
         bus_if.ADDR_IN = 16'($urandom_range(295, 325));
         bus_if.DATA_IN = $urandom;
         bus_if.RD_ADDR = 16'($urandom_range(295, 325));
         tick();
      end
      bus_if.TR_IN = 1'b0;
      idle(20);

      // ERR_CNT saturation.
      for (int i = 0; i < 300; i++) begin
         strobe(16'd0, 32'(i));
         idle(2);
      end
      idle(20);
      chk("err_saturated", 32'(bus_if.ERR_CNT), 32'd255);

      // Reset while a write to 305 sits in COMMIT.
      bus_if.RD_ADDR = 16'd305;
      strobe(16'd305, 32'hCAFE_0305);
      lat = 0;
      while (m_phase != 2 && lat < 10) begin
         tick();
         lat++;
      end
      chk("reach_commit", 32'(m_phase), 32'd2);
      do_reset();
      read_chk("rst_bank5", 16'd305, 32'h0);
      strobe(16'd305, 32'h0000_5555);
      idle(4);
      read_chk("post_rst_write", 16'd305, 32'h0000_5555);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
